// File: rtl/regfile_sb_if.sv
// Register-file bus: write port, read ports, reservation scoreboard handshake.
//   we/wa/wd        write enable, address, data
//   ra/rd/rbusy     packed read addresses, read data, per-port busy flags
//   rsv_valid/rsv_addr/rsv_ready  reservation request and acceptance
//   flush           clear all reservations
//   pend_count      registered number of pending entries
interface regfile_sb_if #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned NREAD  = 2
) ();
   logic                      we;
   logic [AWIDTH-1:0]         wa;
   logic [DWIDTH-1:0]         wd;
   logic [NREAD*AWIDTH-1:0]   ra;
   logic [NREAD*DWIDTH-1:0]   rd;
   logic [NREAD-1:0]          rbusy;
   logic                      rsv_valid;
   logic [AWIDTH-1:0]         rsv_addr;
   logic                      rsv_ready;
   logic                      flush;
   logic [AWIDTH:0]           pend_count;

   modport master (
      output we, wa, wd, ra, rsv_valid, rsv_addr, flush,
      input  rd, rbusy, rsv_ready, pend_count
   );

   modport slave (
      input  we, wa, wd, ra, rsv_valid, rsv_addr, flush,
      output rd, rbusy, rsv_ready, pend_count
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, optional
// hardwired-zero entry 0, optional write-to-read bypass and a per-entry
// pending-write scoreboard.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears data and reservations)
//   bus    regfile_sb_if.slave: write port, read ports with busy flags,
//          reservation handshake, flush and pending-entry count
module regfile_sb #(
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned AWIDTH   = 5,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_sb_if.slave bus
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AWIDTH + 1;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [CW-1:0]     pend_count_q, pend_count_d;

   logic              wv_c;
   logic              rsv_ready_c;
   logic              rsv_set_c;
   logic [IW-1:0]     widx;
   logic [IW-1:0]     sidx;

   function automatic logic in_range(input logic [AWIDTH-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   function automatic logic is_zero(input logic [AWIDTH-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   assign widx = IW'(bus.wa);
   assign sidx = IW'(bus.rsv_addr);

   // Writes to entry 0 (when hardwired) or past DEPTH are dropped entirely.
   assign wv_c = bus.we && in_range(bus.wa) && !is_zero(bus.wa);

   // WAW stall: a pending entry is not re-reservable until written.
   assign rsv_ready_c = !bus.flush && in_range(bus.rsv_addr) && !pend_q[sidx];

   // Reserving the zero register is accepted but leaves no trace.
   assign rsv_set_c = bus.rsv_valid && rsv_ready_c && !is_zero(bus.rsv_addr);

   // Next pending set: write clears, reservation then overrides, flush wins.
   always_comb begin
      pend_d       = pend_q;
      pend_count_d = '0;
      if (wv_c)      pend_d[widx] = 1'b0;
      if (rsv_set_c) pend_d[sidx] = 1'b1;
      if (bus.flush) pend_d       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         pend_count_d = pend_count_d + CW'(pend_d[i]);
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q       <= '0;
         pend_count_q <= '0;
      end else begin
         pend_q       <= pend_d;
         pend_count_q <= pend_count_d;
      end
   end

   // Data storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wv_c) begin
         mem_q[widx] <= bus.wd;
      end
   end

   // Read ports: out-of-range and zero entry read 0; bypass hides a pending
   // entry that is being written this very cycle.
   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AWIDTH-1:0] a;
      logic [IW-1:0]     aidx;
      logic              hit;
      logic [DWIDTH-1:0] rd_c;
      logic              busy_c;

      assign a    = bus.ra[p*AWIDTH +: AWIDTH];
      assign aidx = IW'(a);
      assign hit  = BYPASS && wv_c && (bus.wa == a);

      always_comb begin
         rd_c   = '0;
         busy_c = 1'b0;
         if (in_range(a) && !is_zero(a)) begin
            rd_c   = hit ? bus.wd : mem_q[aidx];
            busy_c = pend_q[aidx] && !hit;
         end
      end

      assign bus.rd[p*DWIDTH +: DWIDTH] = rd_c;
      assign bus.rbusy[p]               = busy_c;
   end

   assign bus.rsv_ready  = rsv_ready_c;
   assign bus.pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb (DEPTH=24, ZERO_REG=1, BYPASS=1).
module tb_regfile_sb;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 2;

   typedef enum int {K_RD, K_BUSY, K_RDY, K_PC} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      int          port;
      logic [31:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   done = 1'b0;
   exp_t sb_q[$];

   regfile_sb_if #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR)) bus ();

   regfile_sb #(
      .DWIDTH(DW), .AWIDTH(AW), .DEPTH(24), .NREAD(NR),
      .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Start a cycle: drive just after the rising edge, all inputs idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.we        = 1'b0;
      bus.wa        = '0;
      bus.wd        = '0;
      bus.ra        = '0;
      bus.rsv_valid = 1'b0;
      bus.rsv_addr  = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic set_ra(input int a0, input int a1);
      bus.ra = {AW'(a1), AW'(a0)};
   endtask

   task automatic expect_v(input string n, input kind_e k, input int p, input logic [31:0] e);
      exp_t x;
      x.name = n; x.kind = k; x.port = p; x.exp = e;
      sb_q.push_back(x);
   endtask

   // Immediate comparison, used where no clock edge may be awaited.
   task automatic check_now(input string n, input logic [31:0] act, input logic [31:0] e);
      tests++;
      if (act !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, e);
      end
   endtask

   // Monitor: outputs are settled by the falling edge; check all queued items.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t x;
         logic [31:0] act;
         x = sb_q.pop_front();
         case (x.kind)
            K_RD:    act = bus.rd[x.port*DW +: DW];
            K_BUSY:  act = 32'(bus.rbusy[x.port]);
            K_RDY:   act = 32'(bus.rsv_ready);
            default: act = 32'(bus.pend_count);
         endcase
         tests++;
         if (act !== x.exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
         end
      end
   end

   // Watchdog: the run must complete within a bounded time.
   initial begin
      #20000;
      if (!done) begin
         fails++;
         $display("FAIL timeout: run did not complete");
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   initial begin
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
      bus.rsv_valid = 1'b0; bus.rsv_addr = '0; bus.flush = 1'b0;

      // In reset
      cyc(); set_ra(5, 7); bus.rsv_addr = 5'd2;
      expect_v("rst_rd0", K_RD, 0, 32'h0);
      expect_v("rst_busy1", K_BUSY, 1, 32'h0);
      expect_v("rst_pc", K_PC, 0, 32'h0);
      expect_v("rst_rdy", K_RDY, 0, 32'h1);
      cyc(); rst_n = 1'b1;

      // Write 5 with same-cycle read: bypass
      cyc(); bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h12345678; set_ra(5, 5);
      expect_v("byp_rd0", K_RD, 0, 32'h12345678);
      expect_v("byp_busy1", K_BUSY, 1, 32'h0);
      cyc(); set_ra(5, 0);
      expect_v("mem5_rd0", K_RD, 0, 32'h12345678);

      // Zero register ignores writes
      cyc(); bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hDEADBEEF; set_ra(0, 5);
      expect_v("zero_byp_rd0", K_RD, 0, 32'h0);
      expect_v("zero_busy0", K_BUSY, 0, 32'h0);
      cyc(); set_ra(0, 0);
      expect_v("zero_rd0", K_RD, 0, 32'h0);

      // Reserve 7, then see busy and WAW stall
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7; set_ra(0, 7);
      expect_v("rsv7_rdy", K_RDY, 0, 32'h1);
      expect_v("rsv7_busy_pre", K_BUSY, 1, 32'h0);
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7; set_ra(0, 7);
      expect_v("rsv7_busy", K_BUSY, 1, 32'h1);
      expect_v("rsv7_pc", K_PC, 0, 32'h1);
      expect_v("rsv7_waw", K_RDY, 0, 32'h0);
      cyc(); bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h00000077; set_ra(0, 7);
      expect_v("wr7_busy_byp", K_BUSY, 1, 32'h0);
      expect_v("wr7_rd1", K_RD, 1, 32'h00000077);
      expect_v("wr7_pc_same", K_PC, 0, 32'h1);
      cyc(); set_ra(0, 7);
      expect_v("wr7_busy", K_BUSY, 1, 32'h0);
      expect_v("wr7_pc", K_PC, 0, 32'h0);

      // Simultaneous write and reserve of 9
      cyc(); bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'hA5A5A5A5;
      bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9; set_ra(9, 0);
      expect_v("wr9_rdy", K_RDY, 0, 32'h1);
      expect_v("wr9_rd0_byp", K_RD, 0, 32'hA5A5A5A5);
      expect_v("wr9_busy0_pre", K_BUSY, 0, 32'h0);
      cyc(); set_ra(9, 0);
      expect_v("wr9_rd0", K_RD, 0, 32'hA5A5A5A5);
      expect_v("wr9_busy0", K_BUSY, 0, 32'h1);
      expect_v("wr9_pc", K_PC, 0, 32'h1);

      // Reserve 3, 4, 6 then flush with a competing request for 10
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd4;
      expect_v("fl_pc2", K_PC, 0, 32'h2);
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd6;
      cyc(); bus.flush = 1'b1; bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd10; set_ra(3, 6);
      expect_v("fl_rdy", K_RDY, 0, 32'h0);
      expect_v("fl_pc4", K_PC, 0, 32'h4);
      expect_v("fl_busy0_pre", K_BUSY, 0, 32'h1);
      cyc(); bus.rsv_addr = 5'd10; set_ra(3, 6);
      expect_v("fl_pc0", K_PC, 0, 32'h0);
      expect_v("fl_busy0", K_BUSY, 0, 32'h0);
      expect_v("fl_busy1", K_BUSY, 1, 32'h0);
      expect_v("fl_rdy10", K_RDY, 0, 32'h1);
      cyc(); set_ra(10, 9);
      expect_v("fl_busy10", K_BUSY, 0, 32'h0);
      expect_v("fl_busy9", K_BUSY, 1, 32'h0);

      // Out of range address 30
      cyc(); bus.we = 1'b1; bus.wa = 5'd30; bus.wd = 32'hFFFFFFFF;
      bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd30; set_ra(30, 5);
      expect_v("oor_rd0", K_RD, 0, 32'h0);
      expect_v("oor_busy0", K_BUSY, 0, 32'h0);
      expect_v("oor_rdy", K_RDY, 0, 32'h0);
      cyc(); set_ra(30, 5);
      expect_v("oor_pc", K_PC, 0, 32'h0);
      expect_v("oor_rd0_post", K_RD, 0, 32'h0);
      expect_v("oor_rd1_keep", K_RD, 1, 32'h12345678);

      // Reserving the zero register is accepted but leaves no state
      cyc(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
      expect_v("rz_rdy", K_RDY, 0, 32'h1);
      cyc(); set_ra(0, 0);
      expect_v("rz_pc", K_PC, 0, 32'h0);
      expect_v("rz_busy0", K_BUSY, 0, 32'h0);

      // Mid-run asynchronous reset
      cyc(); bus.we = 1'b1; bus.wa = 5'd13; bus.wd = 32'h00001313;
      bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd12;
      cyc(); set_ra(12, 13);
      expect_v("pre_rst_busy0", K_BUSY, 0, 32'h1);
      expect_v("pre_rst_rd1", K_RD, 1, 32'h00001313);
      expect_v("pre_rst_pc", K_PC, 0, 32'h1);
      cyc(); rst_n = 1'b0; set_ra(12, 13);
      #1;
      check_now("arst_now_pc", 32'(bus.pend_count), 32'h0);
      check_now("arst_now_busy0", 32'(bus.rbusy[0]), 32'h0);
      check_now("arst_now_rd1", bus.rd[DW +: DW], 32'h0);
      expect_v("arst_busy0", K_BUSY, 0, 32'h0);
      expect_v("arst_rd1", K_RD, 1, 32'h0);
      expect_v("arst_pc", K_PC, 0, 32'h0);
      cyc(); rst_n = 1'b1;
      for (int a = 0; a < 24; a += 2) begin
         cyc(); set_ra(a, a + 1);
         expect_v($sformatf("post_rst_rd_%0d", a), K_RD, 0, 32'h0);
         expect_v($sformatf("post_rst_rd_%0d", a + 1), K_RD, 1, 32'h0);
      end
      cyc();
      expect_v("post_rst_pc", K_PC, 0, 32'h0);

      cyc();
      @(negedge clk);
      #1;
      check_now("sb_q_drained", 32'(sb_q.size()), 32'h0);
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
